// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair: one shift-add or restoring
// shift-subtract step per cycle. Optional macro MULDIV_EARLY_OUT_EN enables multiply early-out.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] ReadData1,
    input  logic [WIDTH-1:0] ReadData2,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    // x: mult = shifted multiplicand; div = {partial remainder, dividend/quotient}
    logic [2*WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]     y_q, y_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic                 is_div_q, is_div_d;
    logic                 qneg_q, qneg_d;
    logic                 rneg_q, rneg_d;
    logic                 done_q, done_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 a_sgn_s, b_sgn_s;
    logic [WIDTH-1:0]     a_mag_s, b_mag_s;
    logic [WIDTH:0]       rem_shift_s, diff_s;
    logic [2*WIDTH-1:0]   mul_res_s;
    logic [WIDTH-1:0]     quo_s, rem_s;

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

    // Next-state, datapath step and HI/LO update selection
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        p_d      = p_q;
        is_div_d = is_div_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        done_d   = 1'b0;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        a_sgn_s     = ~op[0] & ReadData1[WIDTH-1];
        b_sgn_s     = ~op[0] & ReadData2[WIDTH-1];
        a_mag_s     = a_sgn_s ? (-ReadData1) : ReadData1;
        b_mag_s     = b_sgn_s ? (-ReadData2) : ReadData2;
        rem_shift_s = x_q[2*WIDTH-1:WIDTH-1];
        diff_s      = rem_shift_s - {1'b0, y_q};
        mul_res_s   = qneg_q ? (-p_q) : p_q;
        quo_s       = qneg_q ? (-x_q[WIDTH-1:0]) : x_q[WIDTH-1:0];
        rem_s       = rneg_q ? (-x_q[2*WIDTH-1:WIDTH]) : x_q[2*WIDTH-1:WIDTH];

        case (state_q)
            IDLE: begin
                if (hi_we) begin
                    hi_d = wdata;
                end else begin
                    hi_d = hi_q;
                end
                if (lo_we) begin
                    lo_d = wdata;
                end else begin
                    lo_d = lo_q;
                end
                if (start) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    is_div_d = op[1];
                    dz_d     = 1'b0;
                    p_d      = '0;
                    x_d      = {{WIDTH{1'b0}}, a_mag_s};
                    y_d      = b_mag_s;
                    qneg_d   = a_sgn_s ^ b_sgn_s;
                    rneg_d   = a_sgn_s;
                    if (op[1]) begin
                        if (ReadData2 == '0) begin
                            // FIX then emits hi = raw dividend, lo = all ones
                            dz_d    = 1'b1;
                            x_d     = {ReadData1, {WIDTH{1'b1}}};
                            qneg_d  = 1'b0;
                            rneg_d  = 1'b0;
                            state_d = FIX;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        rneg_d = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
                        if (b_mag_s == '0) begin
                            state_d = FIX;
                        end else begin
                            state_d = RUN;
                        end
`endif
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (is_div_q) begin
                    if (!diff_s[WIDTH]) begin
                        x_d = {diff_s[WIDTH-1:0], x_q[WIDTH-2:0], 1'b1};
                    end else begin
                        x_d = {x_q[2*WIDTH-2:0], 1'b0};
                    end
                end else begin
                    if (y_q[0]) begin
                        p_d = p_q + x_q;
                    end else begin
                        p_d = p_q;
                    end
                    x_d = {x_q[2*WIDTH-2:0], 1'b0};
                    y_d = {1'b0, y_q[WIDTH-1:1]};
                end
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
`ifdef MULDIV_EARLY_OUT_EN
                end else if (!is_div_q && (y_q[WIDTH-1:1] == '0)) begin
                    state_d = FIX;
`endif
                end else begin
                    state_d = RUN;
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    hi_d = rem_s;
                    lo_d = quo_s;
                end else begin
                    hi_d = mul_res_s[2*WIDTH-1:WIDTH];
                    lo_d = mul_res_s[WIDTH-1:0];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            p_q      <= '0;
            is_div_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            p_q      <= p_d;
            is_div_q <= is_div_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit using immediate assertions.
module tb_muldiv_unit;
    localparam int W = 32;

    logic          CLK = 1'b0;
    logic          Reset, start, hi_we, lo_we;
    logic [1:0]    op;
    logic [W-1:0]  ReadData1, ReadData2, wdata;
    logic          busy, done, div_zero;
    logic [W-1:0]  hi, lo;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   lat;
    logic busy_mid;
    logic seen_done;

    muldiv_unit #(.WIDTH(W)) dut (
        .CLK(CLK), .Reset(Reset), .start(start), .op(op),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one operation; lat = edges after accept until done is seen (bounded)
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit disturb);
        op = o; ReadData1 = a; ReadData2 = b; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0; ReadData1 = ~a; ReadData2 = ~b;
        lat = 0; busy_mid = 1'b0;
        while (done !== 1'b1 && lat < 100) begin
            if (disturb && lat == 5) begin
                start = 1'b1; hi_we = 1'b1; wdata = 32'h0000_1234; op = 2'b10;
            end else begin
                start = 1'b0; hi_we = 1'b0;
            end
            @(posedge CLK); #1;
            lat++;
            if (lat == W) busy_mid = busy;
        end
        start = 1'b0; hi_we = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; op = 2'b00;
        ReadData1 = 32'h0; ReadData2 = 32'h0; wdata = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        Reset = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dz", {31'd0, div_zero}, 32'd0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);

        // multu max x max
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_lat", lat, 32'd33);
        check("multu_busy_n32", {31'd0, busy_mid}, 32'd1);
        check("multu_busy_done", {31'd0, busy}, 32'd0);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);
        @(posedge CLK); #1;
        check("done_pulse", {31'd0, done}, 32'd0);

        run_op(2'b00, 32'hFFFF_FFF9, 32'd3, 1'b0);
        check("mult_lat", lat, 32'd33);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);

        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_lat", lat, 32'd33);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        run_op(2'b11, 32'd100, 32'd0, 1'b0);
        check("dz_lat", lat, 32'd1);
        check("dz_lo", lo, 32'hFFFF_FFFF);
        check("dz_hi", hi, 32'd100);
        check("dz_flag", {31'd0, div_zero}, 32'd1);

        run_op(2'b11, 32'd100, 32'd7, 1'b0);
        check("divu_lat", lat, 32'd33);
        check("divu_dz_clr", {31'd0, div_zero}, 32'd0);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("divmin_lo", lo, 32'h8000_0000);
        check("divmin_hi", hi, 32'h0);

        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
        check("multmin_hi", hi, 32'h4000_0000);
        check("multmin_lo", lo, 32'h0);

        // start and mthi mid-operation are both dropped
        run_op(2'b01, 32'd6, 32'd7, 1'b1);
        check("dist_lat", lat, 32'd33);
        check("dist_hi", hi, 32'h0);
        check("dist_lo", lo, 32'd42);
        @(posedge CLK); #1;
        check("dist_noq", {31'd0, busy}, 32'd0);

        hi_we = 1'b1; wdata = 32'h0000_1234;
        @(posedge CLK); #1;
        hi_we = 1'b0;
        check("mthi_hi", hi, 32'h0000_1234);
        check("mthi_lo", lo, 32'd42);
        lo_we = 1'b1; wdata = 32'h0000_0055;
        @(posedge CLK); #1;
        lo_we = 1'b0;
        check("mtlo_lo", lo, 32'h0000_0055);

        // reset at edge N+10 of a divu
        op = 2'b11; ReadData1 = 32'd1000; ReadData2 = 32'd3; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (9) @(posedge CLK);
        #1;
        Reset = 1'b1;
        @(posedge CLK); #1;
        Reset = 1'b0;
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_done", {31'd0, done}, 32'd0);
        check("mrst_hi", hi, 32'h0);
        check("mrst_lo", lo, 32'h0);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            if (done === 1'b1) seen_done = 1'b1;
        end
        check("mrst_nodone", {31'd0, seen_done}, 32'd0);

        run_op(2'b01, 32'd5, 32'd1, 1'b0);
`ifdef MULDIV_EARLY_OUT_EN
        check("eo1_lat", lat, 32'd2);
`else
        check("eo1_lat", lat, 32'd33);
`endif
        check("eo1_lo", lo, 32'd5);
        check("eo1_hi", hi, 32'd0);

        run_op(2'b01, 32'd5, 32'd0, 1'b0);
`ifdef MULDIV_EARLY_OUT_EN
        check("eo0_lat", lat, 32'd1);
`else
        check("eo0_lat", lat, 32'd33);
`endif
        check("eo0_lo", lo, 32'd0);
        check("eo0_hi", hi, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
